// File: rtl/wb_ddr3_responder.sv
// Wishbone B4 pipelined slave standing in for the DDR3 controller user port:
// block-RAM storage, fixed ack latency and periodic refresh stalls.
module wb_ddr3_responder #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 64,
  parameter int AUX_WIDTH      = 16,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_STALL  = 6,
  parameter int OPT_BUS_ABORT  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [ADDR_BITS-1:0]   i_wb_addr,
  input  logic [DATA_BITS-1:0]   i_wb_data,
  input  logic [DATA_BITS/8-1:0] i_wb_sel,
  input  logic [AUX_WIDTH-1:0]   i_aux,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic [DATA_BITS-1:0]   o_wb_data,
  output logic [AUX_WIDTH-1:0]   o_aux,
  output logic [3:0]             o_pending
);
  localparam int SELW  = DATA_BITS / 8;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int REFW  = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;

  logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];
  logic [LATENCY-1:0]   r_vld_pipe;
  logic [DATA_BITS-1:0] r_data_pipe [0:LATENCY-1];
  logic [AUX_WIDTH-1:0] r_aux_pipe [0:LATENCY-1];
  logic [REFW-1:0]      r_ref;
  logic                 r_stall;
  logic [3:0]           r_pending;

  logic            w_accept;
  logic            w_abort;
  logic [REFW-1:0] w_ref_nxt;

  assign w_abort   = (OPT_BUS_ABORT != 0) && !i_wb_cyc;
  assign w_accept  = i_wb_stb && !r_stall && (i_wb_cyc || (OPT_BUS_ABORT == 0));
  assign w_ref_nxt = (32'(r_ref) == REFRESH_PERIOD - 1) ? '0 : r_ref + 1'b1;

  // Storage is deliberately unreset so accepted writes survive i_rst.
  always_ff @(posedge i_clk) begin
    if (w_accept && i_wb_we) begin
      for (int b = 0; b < SELW; b++)
        if (i_wb_sel[b]) r_mem[i_wb_addr][8*b +: 8] <= i_wb_data[8*b +: 8];
    end
  end

  // Invalid stages carry zero data/aux so the outputs idle at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data_pipe[i] <= '0;
        r_aux_pipe[i]  <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_data_pipe[i] <= r_data_pipe[i-1];
        r_aux_pipe[i]  <= r_aux_pipe[i-1];
      end
      r_vld_pipe[0]  <= w_accept;
      r_data_pipe[0] <= (w_accept && !i_wb_we) ? r_mem[i_wb_addr] : '0;
      r_aux_pipe[0]  <= w_accept ? i_aux : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_ref   <= w_ref_nxt;
      r_stall <= 32'(w_ref_nxt) >= 32'(REFRESH_PERIOD - REFRESH_STALL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort)
      r_pending <= '0;
    else if (w_accept && !o_wb_ack)
      r_pending <= r_pending + 4'd1;
    else if (!w_accept && o_wb_ack)
      r_pending <= r_pending - 4'd1;
  end

  assign o_wb_stall = r_stall;
  assign o_wb_ack   = r_vld_pipe[LATENCY-1];
  assign o_wb_data  = r_data_pipe[LATENCY-1];
  assign o_aux      = r_aux_pipe[LATENCY-1];
  assign o_pending  = r_pending;
endmodule

// File: tb/tb_wb_ddr3_responder.sv
// Scoreboard bench for wb_ddr3_responder: a monitor pushes expected
// acks on accept and pops them when the DUT acks, checking data, tag and timing.
module tb_wb_ddr3_responder;
  localparam int LAT = 4;

  logic        i_clk = 0;
  logic        i_rst = 1;
  logic        i_wb_cyc = 1;
  logic        i_wb_stb = 0;
  logic        i_wb_we = 0;
  logic [7:0]  i_wb_addr = 0;
  logic [63:0] i_wb_data = 0;
  logic [7:0]  i_wb_sel = 0;
  logic [15:0] i_aux = 0;
  logic        o_wb_stall, o_wb_ack;
  logic [63:0] o_wb_data;
  logic [15:0] o_aux;
  logic [3:0]  o_pending;

  wb_ddr3_responder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_wb_sel(i_wb_sel), .i_aux(i_aux), .o_wb_stall(o_wb_stall),
    .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data), .o_aux(o_aux),
    .o_pending(o_pending));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [63:0] d; logic [15:0] a; int t; } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [63:0] mdl [0:255];
  int checks = 0, failures = 0;
  int cyc_no = 0, refc = 0, nacks = 0, pk = 0;
  bit init = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  always @(negedge i_clk) begin
    cyc_no++;
    if (init) begin
      chk("pending", 64'(o_pending), 64'(q.size()));
      chk("stall", 64'(o_wb_stall), 64'(refc >= 58));
      if (32'(o_pending) > pk) pk = 32'(o_pending);
      if (o_wb_ack) begin
        nacks++;
        if (q.size() == 0) chk("unexp_ack", 1, 0);
        else begin
          e = q.pop_front();
          chk("ack_data", o_wb_data, e.d);
          chk("ack_aux", 64'(o_aux), 64'(e.a));
          chk("ack_lat", 64'(cyc_no), 64'(e.t + LAT));
        end
      end else begin
        chk("idle_data", o_wb_data, 0);
        chk("idle_aux", 64'(o_aux), 0);
      end
    end
    if (i_rst) begin
      q.delete();
      refc = 0;
      init = 1;
    end else begin
      refc = (refc + 1) % 64;
      if (!i_wb_cyc) q.delete();
      else if (init && i_wb_stb && !o_wb_stall) begin
        e.t = cyc_no;
        e.a = i_aux;
        if (i_wb_we) begin
          for (int b = 0; b < 8; b++)
            if (i_wb_sel[b]) mdl[i_wb_addr][8*b +: 8] = i_wb_data[8*b +: 8];
          e.d = 0;
        end else e.d = mdl[i_wb_addr];
        q.push_back(e);
      end
    end
  end

  // Holds the request until accepted, returns just after the accepting edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [63:0] d,
                       input logic [7:0] sel, input logic [15:0] aux);
    bit ok = 0;
    i_wb_stb = 1; i_wb_we = we; i_wb_addr = addr; i_wb_data = d;
    i_wb_sel = sel; i_aux = aux;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge i_clk);
      if (!o_wb_stall) ok = 1;
    end
    if (!ok) chk("stall_timeout", 1, 0);
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input int n);
    i_wb_stb = 0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_window();
    for (int n = 0; n < 70 && refc > 40; n++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic do_reset();
    i_rst = 1;
    @(posedge i_clk); #1;
    i_rst = 0;
  endtask

  int nst, nacc, a0;

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    chk("rst_stall", 64'(o_wb_stall), 0);
    chk("rst_ack", 64'(o_wb_ack), 0);
    chk("rst_data", o_wb_data, 0);
    chk("rst_aux", 64'(o_aux), 0);
    chk("rst_pend", 64'(o_pending), 0);

    issue(1, 8'h61, 64'h6161_6161_6161_6161, 8'hFF, 16'h0011);
    issue(0, 8'h61, 0, 8'h00, 16'h0000);
    idle(8);

    issue(1, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'h0021);
    issue(1, 8'h03, 64'h0, 8'h0F, 16'h0022);
    issue(0, 8'h03, 0, 8'h00, 16'h0023);
    idle(8);
    chk("sel_merge", mdl[3], 64'hFFFF_FFFF_0000_0000);

    for (int i = 1; i <= 8; i++)
      issue(1, 8'(i), {8{8'(i * 17)}}, 8'hFF, 16'(i + 100));
    idle(8);
    wait_window();
    pk = 0;
    for (int i = 1; i <= 8; i++) issue(0, 8'(i), 0, 8'h00, 16'(i));
    idle(8);
    chk("pend_peak", 64'(pk), 64'(LAT));

    do_reset();
    a0 = nacks; nst = 0; nacc = 0;
    i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 8'h61;
    for (int i = 0; i < 70; i++) begin
      i_aux = 16'(i + 500);
      @(negedge i_clk);
      if (o_wb_stall) nst++; else nacc++;
      @(posedge i_clk); #1;
    end
    idle(10);
    chk("stall_cnt", 64'(nst), 6);
    chk("acc_cnt", 64'(nacc), 64);
    chk("hold_acks", 64'(nacks - a0), 64);

    wait_window();
    issue(1, 8'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF, 16'h0040);
    idle(8);
    a0 = nacks;
    issue(0, 8'h01, 0, 8'h00, 16'h0A01);
    issue(0, 8'h02, 0, 8'h00, 16'h0A02);
    issue(0, 8'h03, 0, 8'h00, 16'h0A03);
    i_wb_stb = 0; i_wb_cyc = 0;
    @(posedge i_clk); #1;
    i_wb_cyc = 1;
    idle(8);
    chk("abort_acks", 64'((nacks - a0) <= 1), 1);
    chk("abort_pend", 64'(o_pending), 0);

    wait_window();
    a0 = nacks;
    issue(0, 8'h40, 0, 8'h00, 16'h0B01);
    issue(0, 8'h40, 0, 8'h00, 16'h0B02);
    i_wb_stb = 0;
    do_reset();
    idle(8);
    chk("rst_flush_acks", 64'(nacks - a0), 0);
    chk("rst2_ack", 64'(o_wb_ack), 0);
    chk("rst2_data", o_wb_data, 0);
    chk("rst2_pend", 64'(o_pending), 0);
    a0 = nacks;
    issue(0, 8'h40, 0, 8'h00, 16'h0B03);
    idle(8);
    chk("post_rst_acks", 64'(nacks - a0), 1);
    chk("sb_empty", 64'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc_no);
    $fatal(1, "timeout");
  end
endmodule
